// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the move detector: FSM state codes used both by the
// FSM itself and by the 7-segment debug decoder that displays db_estado.
package detector_jogada_pkg;

   localparam logic [2:0] COD_OCIOSO = 3'd0;
   localparam logic [2:0] COD_FILTRA = 3'd1;
   localparam logic [2:0] COD_ACEITA = 3'd2;
   localparam logic [2:0] COD_ESPERA = 3'd3;
   localparam logic [2:0] COD_SOLTA  = 3'd4;

   typedef enum logic [2:0] {
      OCIOSO = COD_OCIOSO,
      FILTRA = COD_FILTRA,
      ACEITA = COD_ACEITA,
      ESPERA = COD_ESPERA,
      SOLTA  = COD_SOLTA
   } estado_t;

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// Two-flop synchroniser for the raw asynchronous switch bus.
module sincronizador #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // first flop may go metastable; second flop gives the FSM a settled copy
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/detector_jogada.sv
// Move detector: synchronises and debounces the switch bus, accepts one-hot
// presses as moves, flags multi-key presses, and requires a debounced full
// release before the next press is considered.
//
// state  | meaning
// OCIOSO | idle, no key seen
// FILTRA | key seen, counting stable samples of the candidate code
// ACEITA | candidate debounced; emit feita/invalida if enabled (1 cycle)
// ESPERA | press handled, waiting for all keys to be released
// SOLTA  | keys released, counting stable zero samples
module detector_jogada
   import detector_jogada_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] chaves,
   input  logic             enable,
   input  logic             limpa,
   output logic [WIDTH-1:0] jogada,
   output logic             jogada_feita,
   output logic             jogada_invalida,
   output logic [2:0]       db_estado
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] UM     = CW'(1);

   estado_t          estado, estado_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic [WIDTH-1:0] cand, cand_next;
   logic [WIDTH-1:0] jogada_next;
   logic             feita_next, invalida_next;
   logic [WIDTH-1:0] s;
   logic             cand_one_hot;

   sincronizador #(.WIDTH(WIDTH)) u_sinc (
      .clock (clock),
      .reset (reset),
      .d     (chaves),
      .q     (s)
   );

   assign cand_one_hot = (cand != '0) && ((cand & (cand - WIDTH'(1))) == '0);
   assign db_estado    = estado;

   // state, counter, candidate and all outputs are registered together
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado          <= OCIOSO;
         cnt             <= '0;
         cand            <= '0;
         jogada          <= '0;
         jogada_feita    <= 1'b0;
         jogada_invalida <= 1'b0;
      end else begin
         estado          <= estado_next;
         cnt             <= cnt_next;
         cand            <= cand_next;
         jogada          <= jogada_next;
         jogada_feita    <= feita_next;
         jogada_invalida <= invalida_next;
      end
   end

   // next-state, debounce counting and next output values
   always_comb begin
      estado_next   = estado;
      cnt_next      = cnt;
      cand_next     = cand;
      jogada_next   = jogada;
      feita_next    = 1'b0;
      invalida_next = 1'b0;

      case (estado)
         OCIOSO: begin
            if (s != '0) begin
               cand_next   = s;
               cnt_next    = UM;
               estado_next = FILTRA;
            end
         end
         FILTRA: begin
            if (s == '0) begin
               estado_next = OCIOSO;
            end else if (s != cand) begin
               cand_next = s;
               cnt_next  = UM;
            end else if (cnt >= LIMITE) begin
               // >= so that a single-sample debounce accepts on entry
               estado_next = ACEITA;
            end else begin
               cnt_next = cnt + UM;
            end
         end
         ACEITA: begin
            if (enable) begin
               if (cand_one_hot) begin
                  feita_next  = 1'b1;
                  jogada_next = cand;
               end else begin
                  invalida_next = 1'b1;
               end
            end
            estado_next = ESPERA;
         end
         ESPERA: begin
            if (s == '0) begin
               cnt_next    = UM;
               estado_next = SOLTA;
            end
         end
         SOLTA: begin
            if (s != '0) begin
               estado_next = ESPERA;
            end else if (cnt >= LIMITE) begin
               estado_next = OCIOSO;
            end else begin
               cnt_next = cnt + UM;
            end
         end
         default: begin
            estado_next = OCIOSO;
         end
      endcase

      // clearing wins over a same-cycle accept; the pulse itself still fires
      if (limpa) begin
         jogada_next = '0;
      end
   end

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: the stimulus pushes the expected pulse
// (kind, jogada value, cycle) and a monitor compares every pulse the DUT shows.
module tb_detector_jogada;

   localparam int D   = 4;
   // pulse visible at negedge (change cycle + LAT) when chaves changes at a negedge
   localparam int LAT = 3 + D;
   localparam logic [1:0] K_FEITA    = 2'b10;
   localparam logic [1:0] K_INVALIDA = 2'b01;

   typedef struct packed {
      logic [1:0] kind;
      logic [3:0] jog;
      int         cyc;
   } exp_t;

   logic       clock;
   logic       reset;
   logic [3:0] chaves;
   logic       enable;
   logic       limpa;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       jogada_invalida;
   logic [2:0] db_estado;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   detector_jogada #(.WIDTH(4), .DEBOUNCE_CYCLES(D)) dut (
      .clock           (clock),
      .reset           (reset),
      .chaves          (chaves),
      .enable          (enable),
      .limpa           (limpa),
      .jogada          (jogada),
      .jogada_feita    (jogada_feita),
      .jogada_invalida (jogada_invalida),
      .db_estado       (db_estado)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [1:0] kind, input logic [3:0] jog, input int at);
      exp_t e;
      e.kind = kind;
      e.jog  = jog;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic press_expect(input logic [3:0] v, input logic [1:0] kind, input logic [3:0] jog);
      chaves = v;
      push_exp(kind, jog, cyc + LAT);
   endtask

   task automatic release_keys();
      chaves = 4'b0000;
      repeat (10) @(negedge clock);
   endtask

   // monitor: every pulse must match the head of the scoreboard
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         if (sb.size() > 0 && cyc > sb[0].cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL pulse_missing: expected pulse at cycle %0d, none by cycle %0d", sb[0].cyc, cyc);
            void'(sb.pop_front());
         end
         if (jogada_feita || jogada_invalida) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pulse: feita=%0b invalida=%0b at cycle %0d, none expected",
                        jogada_feita, jogada_invalida, cyc);
            end else begin
               e = sb.pop_front();
               check("pulse_kind", int'({jogada_feita, jogada_invalida}), int'(e.kind));
               check("pulse_jogada", int'(jogada), int'(e.jog));
               check("pulse_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      reset  = 1'b0;
      chaves = 4'b0000;
      enable = 1'b0;
      limpa  = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_estado", int'(db_estado), 0);
      check("reset_jogada", int'(jogada), 0);
      check("reset_pulses", int'({jogada_feita, jogada_invalida}), 0);
      reset = 1'b1;

      // 1: idle with no keys
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("idle_estado", int'(db_estado), 0);
         check("idle_jogada", int'(jogada), 0);
      end

      // 2: clean single press
      enable = 1'b1;
      press_expect(4'b0001, K_FEITA, 4'b0001);
      repeat (20) @(negedge clock);
      check("press1_jogada", int'(jogada), 1);
      check("press1_estado", int'(db_estado), 3);
      release_keys();
      check("release_estado", int'(db_estado), 0);

      // 3: bouncing key, then stable
      for (int i = 0; i < 6; i++) begin
         chaves = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         repeat (2) @(negedge clock);
      end
      press_expect(4'b0010, K_FEITA, 4'b0010);
      repeat (20) @(negedge clock);
      check("bounce_jogada", int'(jogada), 2);
      release_keys();

      // 4: two keys at once
      press_expect(4'b0110, K_INVALIDA, 4'b0010);
      repeat (20) @(negedge clock);
      check("multi_jogada", int'(jogada), 2);
      release_keys();

      // 5: press while not enabled, then enable while held
      enable = 1'b0;
      chaves = 4'b1000;
      repeat (20) @(negedge clock);
      enable = 1'b1;
      repeat (10) @(negedge clock);
      check("disabled_estado", int'(db_estado), 3);
      check("disabled_jogada", int'(jogada), 2);
      release_keys();
      press_expect(4'b1000, K_FEITA, 4'b1000);
      repeat (20) @(negedge clock);
      check("reenabled_jogada", int'(jogada), 8);
      release_keys();

      // 7: limpa in the accept cycle wins over the new code, pulse still fires
      press_expect(4'b0001, K_FEITA, 4'b0000);
      repeat (LAT - 1) @(negedge clock);
      limpa = 1'b1;
      @(negedge clock);
      limpa = 1'b0;
      repeat (13) @(negedge clock);
      check("limpa_jogada", int'(jogada), 0);
      release_keys();
      press_expect(4'b0001, K_FEITA, 4'b0001);
      repeat (20) @(negedge clock);
      release_keys();

      // 6: reset while filtering, key still held afterwards
      chaves = 4'b0100;
      repeat (4) @(negedge clock);
      check("prereset_estado", int'(db_estado), 1);
      reset = 1'b0;
      #1;
      check("midreset_estado", int'(db_estado), 0);
      check("midreset_jogada", int'(jogada), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      push_exp(K_FEITA, 4'b0100, cyc + LAT);
      repeat (20) @(negedge clock);
      check("postreset_jogada", int'(jogada), 4);
      release_keys();

      repeat (5) @(negedge clock);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
